instr_encode_loader: RTL and testbench

//  Inverse of the core's immediate sign-extender: packs decoded fields (opcode, regs, funct, immediate)

---
 rtl/instr_encode_loader.sv | 120 ++++++++++++
 tb/tb_instr_encode_loader.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encode_loader.sv
// instr_encode_loader: packs decoded RV32I fields into instruction words and writes them to instruction memory
//   clk, rst (async, active-high)
//   start_i/base_addr_i          : restart loading at base_addr_i (IDLE only), clears count
//   in_valid_i/in_ready_o        : field bundle handshake (opcode_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i)
//   mem_we_o/mem_addr_o/mem_wdata_o/mem_ack_i : write port, request held until ack
//   err_o/err_code_o             : reject pulse, code 01 bad opcode / 10 immediate out of range
//   full_o/count_o               : words written since start/reset, full at DEPTH
module instr_encode_loader #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 256,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [6:0]        opcode_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        rs1_i,
    input  logic [4:0]        rs2_i,
    input  logic [2:0]        funct3_i,
    input  logic [6:0]        funct7_i,
    input  logic [31:0]       imm_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_ack_i,
    output logic              err_o,
    output logic [1:0]        err_code_o,
    output logic              full_o,
    output logic [CW-1:0]     count_o
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic {IDLE, WRITE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic [CW-1:0]     count_q;
    logic              err_q;
    logic [1:0]        err_code_q;

    logic        is_r, is_i, is_s, is_b, op_ok, range_ok, hs, accept, reject;
    logic [1:0]  code;
    logic [31:0] word;

    always_comb begin
        is_r     = opcode_i == OP_R;
        is_i     = opcode_i == OP_LOAD || opcode_i == OP_IMM;
        is_s     = opcode_i == OP_STORE;
        is_b     = opcode_i == OP_BRANCH;
        op_ok    = is_r || is_i || is_s || is_b;
        // a 12-bit signed field holds the value only if bits 31..11 are a pure sign extension
        range_ok = &imm_i[31:11] || ~|imm_i[31:11];
        code     = !op_ok ? 2'b01 : (!is_r && !range_ok) ? 2'b10 : 2'b00;
        // branch offset is already in halfword units, so imm[3:0] lands in [11:8]
        word     = is_r ? {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i} :
                   is_i ? {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i} :
                   is_s ? {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i} :
                          {imm_i[11], imm_i[9:4], rs2_i, rs1_i, funct3_i, imm_i[3:0], imm_i[10], opcode_i};
        hs       = in_valid_i && in_ready_o;
        accept   = hs && code == 2'b00;
        reject   = hs && code != 2'b00;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q == IDLE ? (accept ? WRITE : IDLE) : (mem_ack_i ? IDLE : WRITE);
    end

    // start has priority over a bundle in the same cycle, so it masks in_ready
    always_comb begin
        in_ready_o = !rst && state_q == IDLE && !full_o && !start_i;
        mem_we_o   = state_q == WRITE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q      <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
            err_code_q  <= 2'b00;
        end else begin
            err_q <= reject;
            if (reject) err_code_q <= code;
            if (state_q == IDLE && start_i) begin
                addr_q  <= base_addr_i & ~ADDR_W'(3);
                count_q <= '0;
            end
            if (accept) begin
                mem_addr_q  <= addr_q;
                mem_wdata_q <= word;
            end
            if (state_q == WRITE && mem_ack_i) begin
                addr_q  <= addr_q + ADDR_W'(4);
                count_q <= count_q + CW'(1);
            end
        end
    end

    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign err_o       = err_q;
    assign err_code_o  = err_code_q;
    assign count_o     = count_q;
    assign full_o      = count_q == CW'(DEPTH);
endmodule

// File: tb/tb_instr_encode_loader.sv
// tb_instr_encode_loader: scoreboard bench for instr_encode_loader with hand-computed instruction words
module tb_instr_encode_loader;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0, rst = 1'b1;
    logic          start_i = 1'b0, in_valid_i = 1'b0, mem_ack_i = 1'b0;
    logic [31:0]   base_addr_i = '0, imm_i = '0;
    logic [6:0]    opcode_i = '0, funct7_i = '0;
    logic [4:0]    rd_i = '0, rs1_i = '0, rs2_i = '0;
    logic [2:0]    funct3_i = '0;
    logic          in_ready_o, mem_we_o, err_o, full_o;
    logic [31:0]   mem_addr_o, mem_wdata_o;
    logic [1:0]    err_code_o;
    logic [CW-1:0] count_o;

    instr_encode_loader #(.ADDR_W(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .base_addr_i(base_addr_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .opcode_i(opcode_i),
        .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .funct3_i(funct3_i),
        .funct7_i(funct7_i), .imm_i(imm_i), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i),
        .err_o(err_o), .err_code_o(err_code_o), .full_o(full_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_err;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  code;
    } exp_t;

    exp_t q[$];
    int   n_pass = 0, n_tot = 0;
    logic we_prev = 1'b0;
    exp_t mon_e;

    function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
        n_tot++;
        if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        else n_pass++;
    endfunction

    function automatic void push_w(logic [31:0] a, logic [31:0] d);
        q.push_back('{1'b0, a, d, 2'b00});
    endfunction

    function automatic void push_e(logic [1:0] c);
        q.push_back('{1'b1, 32'h0, 32'h0, c});
    endfunction

    // monitor: compares each new write request and each error pulse with the scoreboard head
    always @(negedge clk) begin
        if (mem_we_o && !we_prev) begin
            if (q.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
            else begin
                mon_e = q.pop_front();
                chk("write_kind", {31'd0, mon_e.is_err}, 32'd0);
                chk("write_addr", mem_addr_o, mon_e.addr);
                chk("write_data", mem_wdata_o, mon_e.data);
            end
        end
        if (err_o) begin
            if (q.size() == 0) chk("unexpected_err", 32'd1, 32'd0);
            else begin
                mon_e = q.pop_front();
                chk("err_kind", {31'd0, mon_e.is_err}, 32'd1);
                chk("err_code", {30'd0, err_code_o}, {30'd0, mon_e.code});
            end
        end
        we_prev = mem_we_o;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] base);
        start_i = 1'b1;
        base_addr_i = base;
        tick();
        start_i = 1'b0;
    endtask

    task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm);
        int n = 0;
        opcode_i = op; rd_i = rd; rs1_i = rs1; rs2_i = rs2;
        funct3_i = f3; funct7_i = f7; imm_i = imm;
        in_valid_i = 1'b1;
        #1;
        while (!in_ready_o && n < 20) begin
            tick();
            #1;
            n++;
        end
        if (!in_ready_o) chk("in_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
    endtask

    task automatic do_ack();
        int n = 0;
        while (!mem_we_o && n < 10) begin
            tick();
            n++;
        end
        if (!mem_we_o) chk("mem_we_timeout", 32'd0, 32'd1);
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [31:0] w;

    initial begin
        #2;
        chk("rst_in_ready", {31'd0, in_ready_o}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we_o}, 32'd0);
        chk("rst_mem_addr", mem_addr_o, 32'h0);
        chk("rst_mem_wdata", mem_wdata_o, 32'h0);
        chk("rst_err_code", {30'd0, err_code_o}, 32'd0);
        chk("rst_count", {29'd0, count_o}, 32'd0);
        chk("rst_full", {31'd0, full_o}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("in_ready_after_rst", {31'd0, in_ready_o}, 32'd1);

        do_start(32'h100);
        push_w(32'h100, 32'h002081B3);
        send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0);
        chk("add_we_n1", {31'd0, mem_we_o}, 32'd1);
        do_ack();
        chk("count_1", {29'd0, count_o}, 32'd1);

        push_w(32'h104, 32'hFFF00293);
        send(7'b0010011, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF);
        do_ack();
        push_w(32'h108, 32'h7FF12083);
        send(7'b0000011, 5'd1, 5'd2, 5'd0, 3'd2, 7'd0, 32'd2047);
        chk("load_imm_field", {20'd0, mem_wdata_o[31:20]}, 32'h7FF);
        do_ack();
        chk("count_3", {29'd0, count_o}, 32'd3);

        do_start(32'h200);
        push_w(32'h200, 32'hFE612E23);
        send(7'b0100011, 5'd0, 5'd2, 5'd6, 3'd2, 7'd0, 32'hFFFFFFFC);
        w = mem_wdata_o;
        chk("store_roundtrip", {{20{w[31]}}, w[31:25], w[11:7]}, 32'hFFFFFFFC);
        do_ack();
        push_w(32'h204, 32'hFE208EE3);
        send(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFE);
        w = mem_wdata_o;
        chk("branch_roundtrip", {{20{w[31]}}, w[31], w[7], w[30:25], w[11:8]}, 32'hFFFFFFFE);
        do_ack();

        push_e(2'b10);
        send(7'b0010011, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        chk("range_err_pulse", {31'd0, err_o}, 32'd1);
        chk("range_no_we", {31'd0, mem_we_o}, 32'd0);
        tick();
        chk("range_err_cleared", {31'd0, err_o}, 32'd0);
        chk("range_code_held", {30'd0, err_code_o}, 32'd2);
        chk("range_count_same", {29'd0, count_o}, 32'd2);
        push_e(2'b01);
        send(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        chk("badop_no_we", {31'd0, mem_we_o}, 32'd0);
        push_w(32'h208, 32'h409403B3);
        send(7'b0110011, 5'd7, 5'd8, 5'd9, 3'd0, 7'b0100000, 32'h12345678);
        do_ack();
        chk("count_after_errs", {29'd0, count_o}, 32'd3);

        do_start(32'h300);
        push_w(32'h300, 32'h00500093);
        send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        for (int i = 0; i < 3; i++) begin
            chk("hold_we", {31'd0, mem_we_o}, 32'd1);
            chk("hold_addr", mem_addr_o, 32'h300);
            chk("hold_wdata", mem_wdata_o, 32'h00500093);
            chk("hold_in_ready", {31'd0, in_ready_o}, 32'd0);
            start_i = (i == 1);
            base_addr_i = 32'h900;
            tick();
        end
        start_i = 1'b0;
        chk("start_in_write_ignored", mem_addr_o, 32'h300);
        rst = 1'b1;
        #1;
        chk("abort_we", {31'd0, mem_we_o}, 32'd0);
        chk("abort_count", {29'd0, count_o}, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        do_start(32'h400);
        for (int i = 1; i <= 4; i++) begin
            case (i)
                1: push_w(32'h400, 32'h00100093);
                2: push_w(32'h404, 32'h00200093);
                3: push_w(32'h408, 32'h00300093);
                default: push_w(32'h40C, 32'h00400093);
            endcase
            send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, i);
            do_ack();
        end
        chk("full_set", {31'd0, full_o}, 32'd1);
        chk("full_count", {29'd0, count_o}, 32'd4);
        chk("full_in_ready", {31'd0, in_ready_o}, 32'd0);
        in_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("full_no_we", {31'd0, mem_we_o}, 32'd0);
        end
        in_valid_i = 1'b0;
        do_start(32'h503);
        chk("restart_full", {31'd0, full_o}, 32'd0);
        chk("restart_count", {29'd0, count_o}, 32'd0);
        push_w(32'h500, 32'h00100093);
        send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        do_ack();

        start_i = 1'b1;
        base_addr_i = 32'h600;
        in_valid_i = 1'b1;
        #1;
        chk("start_masks_ready", {31'd0, in_ready_o}, 32'd0);
        tick();
        start_i = 1'b0;
        in_valid_i = 1'b0;
        chk("start_wins_no_we", {31'd0, mem_we_o}, 32'd0);
        push_w(32'h600, 32'h00200093);
        send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
        do_ack();

        repeat (3) tick();
        chk("scoreboard_empty", q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
